// File: rtl/sipo_frame_driver.sv
// sipo_frame_driver: shifts a parallel word out MSB-first on cs_bar_o/si_o, then holds a deselect gap
//   sc_i, reset_n_i          serial clock, async active-low reset
//   load_data_i/valid_i/ready_o  word handshake (ready only in IDLE)
//   abort_i                  ends the current frame early, no frame_done
//   cs_bar_o, si_o           registered chip select and serial data
//   busy_o, frame_done_o     not-IDLE flag, one-cycle completion pulse
module sipo_frame_driver #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic             sc_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             abort_i,
  output logic             cs_bar_o,
  output logic             si_o,
  output logic             busy_o,
  output logic             frame_done_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
  // With no gap requested the frame end returns straight to IDLE
  localparam state_e END_ST = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_e state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic cs_bar_q, cs_bar_d, si_q, si_d, done_q, done_d;
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_bar_d  = cs_bar_q;
    si_d      = si_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (load_valid_i) begin
        state_d   = SHIFT;
        sr_d      = load_data_i;
        si_d      = load_data_i[WIDTH-1];
        cs_bar_d  = 1'b0;
        bit_cnt_d = BIT_LAST;
      end
      SHIFT: if (abort_i || bit_cnt_q == '0) begin
        state_d   = END_ST;
        cs_bar_d  = 1'b1;
        si_d      = 1'b0;
        done_d    = !abort_i;
        gap_cnt_d = GAP_LOAD;
      end else begin
        // sr_q[WIDTH-2] is the bit after the one currently on si
        sr_d      = sr_q << 1;
        si_d      = sr_q[WIDTH-2];
        bit_cnt_d = bit_cnt_q - 1'b1;
      end
      GAP: begin
        gap_cnt_d = (gap_cnt_q == '0) ? '0 : gap_cnt_q - 1'b1;
        state_d   = (gap_cnt_q == '0) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sc_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_bar_q  <= 1'b1;
      si_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_bar_q  <= cs_bar_d;
      si_q      <= si_d;
      done_q    <= done_d;
    end
  end
  assign load_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign cs_bar_o     = cs_bar_q;
  assign si_o         = si_q;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_sipo_frame_driver.sv
// tb_sipo_frame_driver: randomized and directed checks of two driver configurations against a timeline model
module tb_sipo_frame_driver;
  logic sc = 1'b0, reset_n = 1'b0;
  logic [15:0] a_data = '0;
  logic a_valid = 1'b0, a_abort = 1'b0, a_ready, a_cs, a_si, a_busy, a_done;
  logic [7:0] b_data = '0;
  logic b_valid = 1'b0, b_abort = 1'b0, b_ready, b_cs, b_si, b_busy, b_done;
  always #5 sc = ~sc;
  sipo_frame_driver #(.WIDTH(16), .GAP_CYCLES(2)) dut_a (
    .sc_i(sc), .reset_n_i(reset_n), .load_data_i(a_data), .load_valid_i(a_valid),
    .load_ready_o(a_ready), .abort_i(a_abort), .cs_bar_o(a_cs), .si_o(a_si),
    .busy_o(a_busy), .frame_done_o(a_done));
  sipo_frame_driver #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (
    .sc_i(sc), .reset_n_i(reset_n), .load_data_i(b_data), .load_valid_i(b_valid),
    .load_ready_o(b_ready), .abort_i(b_abort), .cs_bar_o(b_cs), .si_o(b_si),
    .busy_o(b_busy), .frame_done_o(b_done));
  bit sel = 0;
  logic o_cs, o_si, o_ready, o_busy, o_done;
  assign o_cs    = sel ? b_cs : a_cs;
  assign o_si    = sel ? b_si : a_si;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_busy  = sel ? b_busy : a_busy;
  assign o_done  = sel ? b_done : a_done;
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int mw = 16, mg = 2;
  int t = -1, fl = 0;
  bit mab = 0;
  logic [15:0] mword = '0;
  logic [15:0] rx = '0;
  int rx_len = 0, hi_run = 0;
  bit prev_cs = 1, gap_chk = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit idle();
    return t < 0 || t >= fl + mg;
  endfunction
  task automatic model_reset();
    t = -1; fl = 0; mab = 0; rx = '0; rx_len = 0; hi_run = 0; prev_cs = 1;
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic ab, output bit acc);
    logic [31:0] mask;
    bit exp_cs;
    if (sel) begin b_valid = v; b_data = d[7:0]; b_abort = ab; end
    else begin a_valid = v; a_data = d; a_abort = ab; end
    acc = o_ready && v;
    if (!o_cs) begin rx = {rx[14:0], o_si}; rx_len++; end
    @(posedge sc);
    cyc++;
    if (idle() && v) begin
      t = 0; fl = mw; mab = 0; mword = d & 16'((32'd1 << mw) - 1);
    end else if (t >= 0) begin
      if (t < fl && ab) begin fl = t + 1; mab = 1; end
      t++;
    end
    @(negedge sc);
    exp_cs = !(t >= 0 && t < fl);
    check("cs_bar", o_cs, exp_cs);
    check("si", o_si, exp_cs ? 32'd0 : 32'(mword[mw-1-t]));
    check("load_ready", o_ready, idle());
    check("busy", o_busy, !idle());
    check("frame_done", o_done, t >= 0 && t == fl && !mab);
    if (!prev_cs && o_cs) begin
      mask = (32'd1 << fl) - 1;
      check("rx_len", rx_len, fl);
      check("rx_word", 32'(rx) & mask, (32'(mword) >> (mw - fl)) & mask);
      rx = '0; rx_len = 0; hi_run = 0;
    end
    if (prev_cs && !o_cs && gap_chk) check("gap_len", hi_run, mg + 1);
    if (o_cs) hi_run++;
    prev_cs = o_cs;
  endtask
  task automatic idle_steps(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, acc);
  endtask
  task automatic send(input logic [15:0] d, output int c);
    bit acc = 0;
    c = -1;
    for (int i = 0; i < 40 && !acc; i++) step(1, d, 0, acc);
    if (acc) c = cyc;
    else check("accept_timeout", 0, 1);
  endtask
  task automatic random_run(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 29) == 0, acc);
  endtask
  initial begin
    bit acc;
    int c1, c2;
    #12;
    check("rst_cs_a", a_cs, 1);
    check("rst_si_a", a_si, 0);
    check("rst_ready_a", a_ready, 1);
    check("rst_busy_a", a_busy, 0);
    check("rst_done_a", a_done, 0);
    check("rst_cs_b", b_cs, 1);
    check("rst_ready_b", b_ready, 1);
    @(negedge sc);
    reset_n = 1'b1;
    step(1, 16'hA5C3, 0, acc);
    check("single_acc", acc, 1);
    idle_steps(24);
    send(16'h1234, c1);
    gap_chk = 1;
    send(16'hFFFF, c2);
    check("b2b_dist", c2 - c1, 19);
    idle_steps(20);
    gap_chk = 0;
    step(1, 16'h5A3C, 0, acc);
    for (int i = 0; i < 18; i++) step(i % 3 == 1, 16'h0F0F, 0, acc);
    idle_steps(4);
    step(1, 16'hFFFF, 0, acc);
    idle_steps(4);
    step(0, 16'h0, 1, acc);
    check("abort_cs", o_cs, 1);
    step(0, 16'h0, 1, acc);
    check("abort_gap_ready", o_ready, 0);
    step(0, 16'h0, 0, acc);
    check("abort_idle", o_ready, 1);
    idle_steps(3);
    step(1, 16'h3C3C, 0, acc);
    idle_steps(8);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", o_cs, 1);
    check("mid_rst_si", o_si, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    model_reset();
    @(negedge sc);
    reset_n = 1'b1;
    step(1, 16'h8001, 0, acc);
    idle_steps(20);
    random_run(300);
    idle_steps(20);
    sel = 1; mw = 8; mg = 0;
    model_reset();
    send(16'h0081, c1);
    gap_chk = 1;
    send(16'h007E, c2);
    check("b2b8_dist", c2 - c1, 9);
    idle_steps(10);
    gap_chk = 0;
    random_run(200);
    idle_steps(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
